// File: rtl/addr_gen_arbiter_if.sv
// Bus between the address requesters / ADDR_GEN and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface addr_gen_arbiter_if;
  logic [2:0]  iREQ;
  logic [2:0]  iADD_REQ;
  logic [35:0] iOP1;
  logic [35:0] iOP2;
  logic [11:0] iAG_RES;
  logic        oAG_ENABLE;
  logic        oAG_ADD;
  logic [11:0] oAG_OP1;
  logic [11:0] oAG_OP2;
  logic [2:0]  oGNT;
  logic [2:0]  oDONE;
  logic [11:0] oADDR;
  logic        oBUSY;

  modport slave (
    input  iREQ, iADD_REQ, iOP1, iOP2, iAG_RES,
    output oAG_ENABLE, oAG_ADD, oAG_OP1, oAG_OP2, oGNT, oDONE, oADDR, oBUSY
  );

  modport master (
    output iREQ, iADD_REQ, iOP1, iOP2, iAG_RES,
    input  oAG_ENABLE, oAG_ADD, oAG_OP1, oAG_OP2, oGNT, oDONE, oADDR, oBUSY
  );
endinterface

// File: rtl/addr_gen_arbiter.sv
// Round-robin sequencer sharing one asynchronous ADDR_GEN adder among three
// requesters (0 fetch, 1 operand, 2 indirect). Operands are snapshotted at
// grant, the adder is held enabled for SETTLE cycles, then the result is
// registered and returned with a one-cycle done pulse. All outputs are flops.
module addr_gen_arbiter #(
  parameter int unsigned SETTLE = 2
) (
  input  logic                iCLK,
  input  logic                iRST,
  addr_gen_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Counter value during the final ISSUE cycle (counter starts at 0).
  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        add_q, add_d;
  logic [11:0] op1_q, op1_d;
  logic [11:0] op2_q, op2_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  done_q, done_d;
  logic [11:0] addr_q, addr_d;
  logic        busy_q, busy_d;

  logic        any_req;
  logic [1:0]  win;
  logic [1:0]  cand1, cand2, cand3;
  logic [11:0] win_op1, win_op2;
  logic        win_add;

  // Successor of a requester index, modulo 3.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin winner search starting just after the last granted requester.
  always_comb begin
    cand1   = rr_next(last_q);
    cand2   = rr_next(cand1);
    cand3   = rr_next(cand2);
    any_req = |bus.iREQ;
    if (bus.iREQ[cand1]) begin
      win = cand1;
    end else if (bus.iREQ[cand2]) begin
      win = cand2;
    end else begin
      win = cand3;
    end
  end

  // Operand and add-flag slice belonging to the current winner.
  always_comb begin
    case (win)
      2'd0: begin
        win_op1 = bus.iOP1[11:0];
        win_op2 = bus.iOP2[11:0];
        win_add = bus.iADD_REQ[0];
      end
      2'd1: begin
        win_op1 = bus.iOP1[23:12];
        win_op2 = bus.iOP2[23:12];
        win_add = bus.iADD_REQ[1];
      end
      2'd2: begin
        win_op1 = bus.iOP1[35:24];
        win_op2 = bus.iOP2[35:24];
        win_add = bus.iADD_REQ[2];
      end
      default: begin
        win_op1 = 12'd0;
        win_op2 = 12'd0;
        win_add = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs, grant pointer and settle counter.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    add_d  = add_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    gnt_d  = gnt_q;
    done_d = done_q;
    addr_d = addr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          op1_d  = win_op1;
          op2_d  = win_op2;
          add_d  = win_add;
          gnt_d  = 3'b001 << win;
          last_d = win;
          cnt_d  = 4'd0;
          en_d   = 1'b1;
        end else begin
          en_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          addr_d = bus.iAG_RES;
          done_d = gnt_q;
          en_d   = 1'b0;
        end else begin
          en_d   = 1'b1;
        end
      end
      S_RELEASE: begin
        done_d = 3'b000;
        gnt_d  = 3'b000;
        en_d   = 1'b0;
      end
      default: begin
        done_d = 3'b000;
        gnt_d  = 3'b000;
        en_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output, pointer and counter registers; reset drops any in-flight operation.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      last_q <= 2'd2;
      cnt_q  <= 4'd0;
      en_q   <= 1'b0;
      add_q  <= 1'b0;
      op1_q  <= 12'o0000;
      op2_q  <= 12'o0000;
      gnt_q  <= 3'b000;
      done_q <= 3'b000;
      addr_q <= 12'o0000;
      busy_q <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      add_q  <= add_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      addr_q <= addr_d;
      busy_q <= busy_d;
    end
  end

  assign bus.oAG_ENABLE = en_q;
  assign bus.oAG_ADD    = add_q;
  assign bus.oAG_OP1    = op1_q;
  assign bus.oAG_OP2    = op2_q;
  assign bus.oGNT       = gnt_q;
  assign bus.oDONE      = done_q;
  assign bus.oADDR      = addr_q;
  assign bus.oBUSY      = busy_q;

endmodule

// File: tb/tb_addr_gen_arbiter.sv
// Bench for addr_gen_arbiter with a behavioural zero-delay ADDR_GEN.
module tb_addr_gen_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  addr_gen_arbiter_if bus ();

  addr_gen_arbiter #(.SETTLE(2)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ADDR_GEN: drives 0 when not enabled.
  assign bus.iAG_RES = bus.oAG_ENABLE ?
                       (bus.oAG_ADD ? (bus.oAG_OP1 + bus.oAG_OP2) : bus.oAG_OP2) : 12'd0;

  typedef struct {
    logic [2:0]  done;
    logic [11:0] addr;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          idx;
    logic        add;
    logic [11:0] op1;
    logic [11:0] op2;
    logic [11:0] exp_addr;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && bus.oDONE != 3'b000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {33'd0, bus.oDONE}, 36'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_done", {33'd0, bus.oDONE}, {33'd0, e.done});
        check("sb_addr", {24'd0, bus.oADDR}, {24'd0, e.addr});
      end
    end
  end

  task automatic set_ops(input int idx, input logic add, input logic [11:0] op1,
                         input logic [11:0] op2);
    bus.iADD_REQ[idx] = add;
    bus.iOP1[12*idx +: 12] = op1;
    bus.iOP2[12*idx +: 12] = op2;
  endtask

  task automatic push(input logic [2:0] done, input logic [11:0] addr);
    exp_t e;
    e.done = done;
    e.addr = addr;
    sb_q.push_back(e);
  endtask

  // Waits at negedges for a done pulse; returns cycles waited.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.oDONE != 3'b000) begin
        cyc = c;
        break;
      end
    end
    if (cyc == 0) check({name, "_timeout"}, 36'd1, 36'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1 rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int   cyc;
  int   done_cyc[5];
  logic [2:0] done_val[5];

  initial begin
    bus.iREQ = 3'b000;
    bus.iADD_REQ = 3'b000;
    bus.iOP1 = 36'd0;
    bus.iOP2 = 36'd0;

    vecs[0] = '{idx: 0, add: 1'b1, op1: 12'o7777, op2: 12'o0002, exp_addr: 12'o0001};
    vecs[1] = '{idx: 2, add: 1'b0, op1: 12'o4444, op2: 12'o0123, exp_addr: 12'o0123};
    vecs[2] = '{idx: 1, add: 1'b1, op1: 12'o1234, op2: 12'o1111, exp_addr: 12'o2345};
    vecs[3] = '{idx: 0, add: 1'b0, op1: 12'o0001, op2: 12'o7070, exp_addr: 12'o7070};

    // Reset held 2 cycles: all outputs zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enable", {35'd0, bus.oAG_ENABLE}, 36'd0);
    check("rst_add",    {35'd0, bus.oAG_ADD}, 36'd0);
    check("rst_op1",    {24'd0, bus.oAG_OP1}, 36'd0);
    check("rst_op2",    {24'd0, bus.oAG_OP2}, 36'd0);
    check("rst_gnt",    {33'd0, bus.oGNT}, 36'd0);
    check("rst_done",   {33'd0, bus.oDONE}, 36'd0);
    check("rst_addr",   {24'd0, bus.oADDR}, 36'd0);
    check("rst_busy",   {35'd0, bus.oBUSY}, 36'd0);

    // Basic timing: requester 1, 7000+0777.
    @(posedge clk); #1 rst = 1'b0;
    set_ops(1, 1'b1, 12'o7000, 12'o0777);
    bus.iREQ = 3'b010;
    push(3'b010, 12'o7777);
    @(negedge clk);
    check("t0_enable", {35'd0, bus.oAG_ENABLE}, 36'd0);
    @(negedge clk);
    check("t1_enable", {35'd0, bus.oAG_ENABLE}, 36'd1);
    check("t1_gnt",    {33'd0, bus.oGNT}, 36'b010);
    check("t1_add",    {35'd0, bus.oAG_ADD}, 36'd1);
    check("t1_busy",   {35'd0, bus.oBUSY}, 36'd1);
    @(negedge clk);
    check("t2_enable", {35'd0, bus.oAG_ENABLE}, 36'd1);
    @(negedge clk);
    check("t3_done",   {33'd0, bus.oDONE}, 36'b010);
    check("t3_addr",   {24'd0, bus.oADDR}, {24'd0, 12'o7777});
    check("t3_enable", {35'd0, bus.oAG_ENABLE}, 36'd0);
    @(posedge clk); #1 bus.iREQ = 3'b000;
    @(negedge clk);
    check("t4_busy",   {35'd0, bus.oBUSY}, 36'd0);
    check("t4_gnt",    {33'd0, bus.oGNT}, 36'd0);
    check("t4_addr_hold", {24'd0, bus.oADDR}, {24'd0, 12'o7777});

    // Table-driven single operations.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      set_ops(vecs[v].idx, vecs[v].add, vecs[v].op1, vecs[v].op2);
      bus.iREQ = 3'b001 << vecs[v].idx;
      push(3'b001 << vecs[v].idx, vecs[v].exp_addr);
      @(negedge clk); @(negedge clk);
      check("vec_gnt", {33'd0, bus.oGNT}, {33'd0, 3'b001 << vecs[v].idx});
      check("vec_add", {35'd0, bus.oAG_ADD}, {35'd0, vecs[v].add});
      wait_done("vec", cyc);
      check("vec_latency", 36'(cyc), 36'd2);
      @(posedge clk); #1 bus.iREQ = 3'b000;
    end

    // Round robin with all requests held from reset.
    @(posedge clk); #1 rst = 1'b1;
    set_ops(0, 1'b0, 12'd0, 12'o0100);
    set_ops(1, 1'b0, 12'd0, 12'o0200);
    set_ops(2, 1'b0, 12'd0, 12'o0300);
    bus.iREQ = 3'b111;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    push(3'b001, 12'o0100); push(3'b010, 12'o0200); push(3'b100, 12'o0300);
    push(3'b001, 12'o0100); push(3'b010, 12'o0200);
    cyc = 0;
    for (int k = 0; k < 5; k++) begin
      done_cyc[k] = 0;
      done_val[k] = 3'b000;
    end
    for (int c = 1, k = 0; c <= 40 && k < 5; c++) begin
      @(negedge clk);
      if (bus.oDONE != 3'b000) begin
        done_cyc[k] = c;
        done_val[k] = bus.oDONE;
        k++;
      end
    end
    @(posedge clk); #1 bus.iREQ = 3'b000;
    check("rr_order0", {33'd0, done_val[0]}, 36'b001);
    check("rr_order1", {33'd0, done_val[1]}, 36'b010);
    check("rr_order2", {33'd0, done_val[2]}, 36'b100);
    check("rr_order3", {33'd0, done_val[3]}, 36'b001);
    check("rr_order4", {33'd0, done_val[4]}, 36'b010);
    for (int k = 1; k < 5; k++)
      check("rr_spacing", 36'(done_cyc[k] - done_cyc[k-1]), 36'd4);

    // Snapshot: OP2 changes in the first ISSUE cycle must not matter.
    @(posedge clk); #1;
    set_ops(1, 1'b0, 12'd0, 12'o0010);
    bus.iREQ = 3'b010;
    push(3'b010, 12'o0010);
    @(posedge clk); #1 set_ops(1, 1'b1, 12'o0005, 12'o0020);
    wait_done("snap", cyc);
    check("snap_op2", {24'd0, bus.oAG_OP2}, {24'd0, 12'o0010});
    @(posedge clk); #1 bus.iREQ = 3'b000;

    // Reset in second ISSUE cycle; pointer must return to favouring 0.
    @(posedge clk); #1;
    set_ops(0, 1'b0, 12'd0, 12'o0555);
    set_ops(1, 1'b0, 12'd0, 12'o0666);
    bus.iREQ = 3'b011;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push(3'b001, 12'o0555);
    @(negedge clk);
    check("mid_rst_enable", {35'd0, bus.oAG_ENABLE}, 36'd0);
    check("mid_rst_busy",   {35'd0, bus.oBUSY}, 36'd0);
    check("mid_rst_done",   {33'd0, bus.oDONE}, 36'd0);
    check("mid_rst_addr",   {24'd0, bus.oADDR}, 36'd0);
    @(negedge clk);
    check("post_rst_gnt",   {33'd0, bus.oGNT}, 36'b001);
    wait_done("post_rst", cyc);
    @(posedge clk); #1 bus.iREQ = 3'b000;
    repeat (4) @(negedge clk);
    check("sb_empty", 36'(sb_q.size()), 36'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
